// File: rtl/axi4lite_client_arbiter_pkg.sv
// Shared constants and types for the AXI4-Lite client arbiter.
package axi4lite_client_arbiter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    BRESP,
    READ,
    RDATA_WAIT
  } state_e;

  // Width of a client index; a single client still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4lite_client_arbiter_if.sv
// AXI4-Lite bus between the arbiter (master) and the shared slave.
interface axi4lite_client_arbiter_if #(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 32
);
  localparam int unsigned strb_width = data_width / 8;

  logic                  AWVALID;
  logic                  AWREADY;
  logic [addr_width-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [data_width-1:0] WDATA_M;
  logic [strb_width-1:0] WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [addr_width-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [data_width-1:0] RDATA_M;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA_M, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA_M, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA_M, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA_M, RRESP
  );

endinterface

// File: rtl/axi4lite_client_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request above last_i, wrapping around.
module rr_arbiter
  import axi4lite_client_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS = 2,
  localparam int unsigned IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      cand = IDX_W'((32'(last_i) + k) % NUM_CLIENTS);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axi4lite_client_arbiter.sv
// Shares one AXI4-Lite slave among NUM_CLIENTS req/ack clients, one
// transaction at a time, granted round-robin.
module axi4lite_client_arbiter
  import axi4lite_client_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned data_width  = 32,
  parameter int unsigned addr_width  = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_CLIENTS-1:0]            REQ,
  input  logic [NUM_CLIENTS-1:0]            WE,
  input  logic [NUM_CLIENTS*addr_width-1:0] ADDR,
  input  logic [NUM_CLIENTS*data_width-1:0] WDATA,
  output logic [NUM_CLIENTS-1:0]            ACK,
  output logic [data_width-1:0]             RDATA,
  output logic                              ERR,
  axi4lite_client_arbiter_if.master         axi
);

  localparam int unsigned strb_width = data_width / 8;
  localparam int unsigned IDX_W      = idx_width(NUM_CLIENTS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_CLIENTS-1:0]  grant_oh_q, grant_oh_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [NUM_CLIENTS-1:0]  ack_q, ack_d;
  logic                    err_q, err_d;
  logic [data_width-1:0]   rdata_q, rdata_d;

  logic [NUM_CLIENTS-1:0]  arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic                    aw_done, w_done;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr_arbiter (
    .req_i   (REQ),
    .last_i  (last_grant_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_CLIENTS - 1);
      grant_oh_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_oh_q   <= grant_oh_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_oh_d   = grant_oh_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    ack_d        = '0;
    err_d        = err_q;
    rdata_d      = rdata_q;
    aw_done      = 1'b0;
    w_done       = 1'b0;

    unique case (state_q)
      // Skip the ACK cycle: the acknowledged client still shows REQ then.
      IDLE: begin
        if (arb_valid && (ack_q == '0)) begin
          last_grant_d = arb_idx;
          grant_oh_d   = arb_gnt;
          addr_d       = ADDR[32'(arb_idx)*addr_width +: addr_width];
          wdata_d      = WDATA[32'(arb_idx)*data_width +: data_width];
          if (WE[arb_idx]) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W channels complete independently, in either order.
      WRITE: begin
        aw_done = !awvalid_q || axi.AWREADY;
        w_done  = !wvalid_q || axi.WREADY;
        if (awvalid_q && axi.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && axi.WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = BRESP;
          bready_d = 1'b1;
        end
      end

      BRESP: begin
        if (axi.BVALID) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          ack_d    = grant_oh_q;
          err_d    = (axi.BRESP != RESP_OKAY);
        end
      end

      READ: begin
        if (axi.ARREADY) begin
          state_d   = RDATA_WAIT;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      RDATA_WAIT: begin
        if (axi.RVALID) begin
          state_d  = IDLE;
          rready_d = 1'b0;
          ack_d    = grant_oh_q;
          err_d    = (axi.RRESP != RESP_OKAY);
          rdata_d  = axi.RDATA_M;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign axi.AWVALID = awvalid_q;
  assign axi.AWADDR  = addr_q;
  assign axi.AWPROT  = 3'b000;
  assign axi.WVALID  = wvalid_q;
  assign axi.WDATA_M = wdata_q;
  assign axi.WSTRB   = {strb_width{1'b1}};
  assign axi.BREADY  = bready_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARPROT  = 3'b000;
  assign axi.RREADY  = rready_q;

  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_axi4lite_client_arbiter.sv
// Scoreboard bench for axi4lite_client_arbiter with a small register-file slave.
module tb_axi4lite_client_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [N-1:0]  ack;
    logic          err;
    logic          chk;
    logic [DW-1:0] rdata;
  } exp_t;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    REQ, WE, ACK;
  logic [N*AW-1:0] ADDR;
  logic [N*DW-1:0] WDATA;
  logic [DW-1:0]   RDATA;
  logic            ERR;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 ACLK = ~ACLK;

  axi4lite_client_arbiter_if #(.addr_width(AW), .data_width(DW)) axi ();

  axi4lite_client_arbiter #(
    .NUM_CLIENTS (N),
    .data_width  (DW),
    .addr_width  (AW)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .REQ    (REQ),
    .WE     (WE),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .ACK    (ACK),
    .RDATA  (RDATA),
    .ERR    (ERR),
    .axi    (axi)
  );

  // Register-file slave: optional W delay after AW, configurable RRESP.
  logic          aw_got, w_got, aw_fire, w_fire;
  logic [AW-1:0] awaddr_s;
  logic [DW-1:0] wdata_s;
  logic [2:0]    wsel;
  int unsigned   wcnt, w_delay;
  logic [1:0]    rresp_cfg;
  logic [DW-1:0] mem [8];

  assign axi.AWREADY = !aw_got && !axi.BVALID;
  assign axi.WREADY  = !w_got && !axi.BVALID && ((w_delay == 0) || (aw_got && (wcnt >= w_delay)));
  assign axi.ARREADY = !axi.RVALID;
  assign aw_fire     = axi.AWVALID && axi.AWREADY;
  assign w_fire      = axi.WVALID && axi.WREADY;
  assign wsel        = aw_fire ? axi.AWADDR[4:2] : awaddr_s[4:2];

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      wcnt        <= 0;
      awaddr_s    <= '0;
      wdata_s     <= '0;
      axi.BVALID  <= 1'b0;
      axi.BRESP   <= 2'b00;
      axi.RVALID  <= 1'b0;
      axi.RDATA_M <= '0;
      axi.RRESP   <= 2'b00;
      for (int k = 0; k < 8; k++) mem[k] <= '0;
    end else begin
      if (aw_fire) awaddr_s <= axi.AWADDR;
      if (w_fire)  wdata_s  <= axi.WDATA_M;
      if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
      if ((aw_got || aw_fire) && (w_got || w_fire)) begin
        mem[wsel]  <= w_fire ? axi.WDATA_M : wdata_s;
        axi.BVALID <= 1'b1;
        axi.BRESP  <= 2'b00;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        wcnt       <= 0;
      end else begin
        aw_got <= aw_got || aw_fire;
        w_got  <= w_got || w_fire;
        if (aw_got && !w_got) wcnt <= wcnt + 1;
      end
      if (axi.RVALID && axi.RREADY) axi.RVALID <= 1'b0;
      if (axi.ARVALID && axi.ARREADY) begin
        axi.RVALID  <= 1'b1;
        axi.RDATA_M <= mem[axi.ARADDR[4:2]];
        axi.RRESP   <= rresp_cfg;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ack(input logic [N-1:0] ack, input logic err, input logic chk,
                            input logic [DW-1:0] rdata);
    exp_t e;
    e.ack = ack; e.err = err; e.chk = chk; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Raise REQ, hold until ACK (bounded), then drop; lat = negedges to ACK.
  task automatic client_txn(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    @(negedge ACLK);
    WE[i]            = we;
    ADDR[i*AW +: AW] = a;
    WDATA[i*DW +: DW] = d;
    REQ[i]           = 1'b1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge ACLK);
      lat++;
      if (ACK[i]) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: client %0d got no ACK within 200 cycles", i);
    end
    REQ[i] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // Monitor: every ACK pulse is matched against the next expectation.
  always @(negedge ACLK) begin
    if (ACK != '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: ACK=%b with no pending expectation at %0t", ACK, $time);
      end else begin
        mon_e = exp_q.pop_front();
        cmp("ack_pattern", 32'(ACK), 32'(mon_e.ack));
        cmp("ack_err", 32'(ERR), 32'(mon_e.err));
        if (mon_e.chk) cmp("ack_rdata", RDATA, mon_e.rdata);
      end
    end
  end

  task automatic check_idle_bus(input string tag);
    cmp({tag, "_awvalid"}, 32'(axi.AWVALID), 0);
    cmp({tag, "_wvalid"},  32'(axi.WVALID), 0);
    cmp({tag, "_bready"},  32'(axi.BREADY), 0);
    cmp({tag, "_arvalid"}, 32'(axi.ARVALID), 0);
    cmp({tag, "_rready"},  32'(axi.RREADY), 0);
    cmp({tag, "_ack"},     32'(ACK), 0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    ARESET    = 1'b1;
    REQ       = '0;
    WE        = '0;
    ADDR      = '0;
    WDATA     = '0;
    w_delay   = 0;
    rresp_cfg = 2'b00;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    check_idle_bus("reset");
    cmp("reset_err",    32'(ERR), 0);
    cmp("reset_rdata",  RDATA, 0);
    cmp("reset_awprot", 32'(axi.AWPROT), 0);
    cmp("reset_arprot", 32'(axi.ARPROT), 0);
    cmp("reset_wstrb",  32'(axi.WSTRB), 32'hF);

    // Single write then readback, with zero-wait latency.
    expect_ack(2'b01, 1'b0, 1'b0, '0);
    client_txn(0, 1'b1, 5'h08, 32'hDEADBEEF, lat);
    cmp("write_latency", 32'(lat), 3);
    expect_ack(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
    client_txn(0, 1'b0, 5'h08, '0, lat);
    cmp("read_latency", 32'(lat), 3);

    // Both clients request right after reset: client 0 first.
    apply_reset();
    expect_ack(2'b01, 1'b0, 1'b0, '0);
    expect_ack(2'b10, 1'b0, 1'b0, '0);
    fork
      begin int l0; client_txn(0, 1'b1, 5'h04, 32'h11, l0); end
      begin int l1; client_txn(1, 1'b1, 5'h0C, 32'h22, l1); end
    join
    expect_ack(2'b01, 1'b0, 1'b1, 32'h22);
    client_txn(0, 1'b0, 5'h0C, '0, lat);
    expect_ack(2'b10, 1'b0, 1'b1, 32'h11);
    client_txn(1, 1'b0, 5'h04, '0, lat);

    // Continuous re-requests alternate 0,1,0,1.
    expect_ack(2'b01, 1'b0, 1'b0, '0);
    expect_ack(2'b10, 1'b0, 1'b0, '0);
    expect_ack(2'b01, 1'b0, 1'b1, 32'hC1);
    expect_ack(2'b10, 1'b0, 1'b1, 32'hA0);
    fork
      begin
        int l0;
        client_txn(0, 1'b1, 5'h00, 32'hA0, l0);
        client_txn(0, 1'b0, 5'h1C, '0, l0);
      end
      begin
        int l1;
        client_txn(1, 1'b1, 5'h1C, 32'hC1, l1);
        client_txn(1, 1'b0, 5'h00, '0, l1);
      end
    join

    // WREADY held off 3 cycles after the AW handshake.
    w_delay = 3;
    expect_ack(2'b10, 1'b0, 1'b0, '0);
    fork
      begin int l1; client_txn(1, 1'b1, 5'h18, 32'h12345678, l1); end
      begin
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge ACLK);
          if (axi.AWVALID && axi.AWREADY) seen = 1;
        end
        cmp("aw_handshake_seen", 32'(seen), 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge ACLK);
          cmp("wvalid_held", 32'(axi.WVALID), 1);
          cmp("wready_low",  32'(axi.WREADY), 0);
          cmp("wdata_stable", axi.WDATA_M, 32'h12345678);
          cmp("awvalid_dropped", 32'(axi.AWVALID), 0);
        end
        @(negedge ACLK);
        cmp("w_handshake", 32'(axi.WVALID && axi.WREADY), 1);
        @(negedge ACLK);
        cmp("wvalid_after_hs", 32'(axi.WVALID), 0);
      end
    join
    w_delay = 0;

    // Error response on a read, then a clean read.
    rresp_cfg = 2'b10;
    expect_ack(2'b01, 1'b1, 1'b1, 32'h12345678);
    client_txn(0, 1'b0, 5'h18, '0, lat);
    @(negedge ACLK);
    cmp("err_hold", 32'(ERR), 1);
    rresp_cfg = 2'b00;
    expect_ack(2'b01, 1'b0, 1'b1, 32'h11);
    client_txn(0, 1'b0, 5'h04, '0, lat);

    // Reset while waiting for the write response abandons the transaction.
    @(negedge ACLK);
    WE[0]        = 1'b1;
    ADDR[0 +: AW] = 5'h10;
    WDATA[0 +: DW] = 32'h99;
    REQ[0]       = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge ACLK);
      if (axi.BREADY) seen = 1;
    end
    cmp("bready_seen", 32'(seen), 1);
    ARESET = 1'b1;
    REQ[0] = 1'b0;
    @(negedge ACLK);
    check_idle_bus("midreset");
    cmp("midreset_rdata", RDATA, 0);
    ARESET = 1'b0;

    expect_ack(2'b01, 1'b0, 1'b0, '0);
    expect_ack(2'b10, 1'b0, 1'b0, '0);
    fork
      begin int l0; client_txn(0, 1'b1, 5'h10, 32'h55, l0); end
      begin int l1; client_txn(1, 1'b1, 5'h14, 32'h66, l1); end
    join
    expect_ack(2'b01, 1'b0, 1'b1, 32'h55);
    client_txn(0, 1'b0, 5'h10, '0, lat);
    expect_ack(2'b10, 1'b0, 1'b1, 32'h66);
    client_txn(1, 1'b0, 5'h14, '0, lat);

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge ACLK);
    repeat (4) @(negedge ACLK);
    cmp("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
